// File: rtl/fifo_chk_pkg.sv
// Shared types and helpers for the in-circuit FIFO flag checker.
// Consumed by fifo_flag_checker and its optional shadow-memory sub-block.
package fifo_chk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } chk_state_e;

   typedef enum logic [3:0] {
      NONE       = 4'd0,
      FULL_MIS   = 4'd1,
      EMPTY_MIS  = 4'd2,
      AFULL_MIS  = 4'd3,
      AEMPTY_MIS = 4'd4,
      WRACK_MIS  = 4'd5,
      OVF_MIS    = 4'd6,
      UDF_MIS    = 4'd7,
      DATA_MIS   = 4'd8
   } chk_err_e;

   localparam int NUM_MIS = 8;

   typedef struct packed {
      logic full;
      logic empty;
      logic afull;
      logic aempty;
   } comb_flags_t;

   // Combinational FIFO status implied by an occupancy of cnt entries.
   function automatic comb_flags_t exp_comb_flags(input int cnt, input int depth);
      comb_flags_t f;
      f.full   = (cnt == depth);
      f.empty  = (cnt == 0);
      f.afull  = (cnt == depth - 1);
      f.aempty = (cnt == 1);
      return f;
   endfunction

endpackage

// File: rtl/fifo_chk_shadow_mem.sv
// Shadow copy of the observed FIFO storage, used to predict data_out.
// Built only when FIFO_CHK_DATA_EN is defined.
module fifo_chk_shadow_mem #(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_acc,
   input  logic                  rd_acc,
   input  logic [FIFO_WIDTH-1:0] data_in,
   output logic [FIFO_WIDTH-1:0] head_word
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;

   // Depth is a power of two, so pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= data_in;
   end

   assign head_word = mem[rd_ptr];

endmodule

// File: rtl/fifo_flag_checker.sv
// Passive checker: shadows FIFO occupancy and counts flag/handshake mismatches.
// Define FIFO_CHK_DATA_EN to also check read data against a shadow memory.
module fifo_flag_checker
   import fifo_chk_pkg::*;
#(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  chk_en,
   input  logic                  halt_on_err,
   input  logic                  err_clr,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [FIFO_WIDTH-1:0] data_in,
   input  logic [FIFO_WIDTH-1:0] data_out,
   input  logic                  wr_ack,
   input  logic                  overflow,
   input  logic                  underflow,
   input  logic                  full,
   input  logic                  empty,
   input  logic                  almostfull,
   input  logic                  almostempty,
   output logic                  err_sticky,
   output logic [CNT_W-1:0]      err_count,
   output logic [CNT_W-1:0]      chk_count,
   output logic [3:0]            first_err_code,
   output logic [1:0]            state
);
   localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [3:0]       b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + (CNT_W+1)'(b);
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   function automatic logic [3:0] mis_count(input logic [NUM_MIS:1] m);
      logic [3:0] n;
      n = '0;
      for (int i = 1; i <= NUM_MIS; i++) n = n + {3'b000, m[i]};
      return n;
   endfunction

   // Scanning downward leaves the lowest set code in c.
   function automatic logic [3:0] lowest_code(input logic [NUM_MIS:1] m);
      logic [3:0] c;
      c = 4'(NONE);
      for (int i = NUM_MIS; i >= 1; i--) begin
         if (m[i]) c = 4'(i);
      end
      return c;
   endfunction

   chk_state_e          state_q;
   chk_err_e            first_err_q;
   logic [OCC_W-1:0]    cnt;
   logic                wr_acc;
   logic                rd_acc;
   logic                run;
   logic                any_mis;
   logic                data_mis;
   logic [NUM_MIS:1]    mis;
   comb_flags_t         exp_comb;
   logic                exp_wr_ack_p1;
   logic                exp_ovf_p1;
   logic                exp_udf_p1;
   logic                reg_vld_p1;

   assign wr_acc   = wr_en & (cnt < OCC_W'(FIFO_DEPTH));
   assign rd_acc   = rd_en & (cnt != '0);
   assign exp_comb = exp_comb_flags(int'(cnt), FIFO_DEPTH);
   assign run      = (state_q == RUN);

   // ---- stage p0: shadow occupancy and expected registered flags ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         exp_wr_ack_p1 <= 1'b0;
         exp_ovf_p1    <= 1'b0;
         exp_udf_p1    <= 1'b0;
         reg_vld_p1    <= 1'b0;
      end else begin
         case ({wr_acc, rd_acc})
            2'b10:   cnt <= cnt + OCC_W'(1);
            2'b01:   cnt <= cnt - OCC_W'(1);
            default: cnt <= cnt;
         endcase
         exp_wr_ack_p1 <= wr_acc;
         exp_ovf_p1    <= wr_en & (cnt == OCC_W'(FIFO_DEPTH));
         exp_udf_p1    <= rd_en & (cnt == '0);
         reg_vld_p1    <= 1'b1;
      end
   end

`ifdef FIFO_CHK_DATA_EN
   logic [FIFO_WIDTH-1:0] head_word;
   logic [FIFO_WIDTH-1:0] exp_data_p1;
   logic                  data_vld_p1;

   fifo_chk_shadow_mem #(
      .FIFO_WIDTH (FIFO_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_shadow_mem (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_acc    (wr_acc),
      .rd_acc    (rd_acc),
      .data_in   (data_in),
      .head_word (head_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_vld_p1 <= 1'b0;
      else        data_vld_p1 <= rd_acc;
   end

   always_ff @(posedge clk) begin
      if (rd_acc) exp_data_p1 <= head_word;
   end

   assign data_mis = data_vld_p1 & (data_out != exp_data_p1);
`else
   logic unused_data;
   assign unused_data = ^{data_in, data_out};
   assign data_mis    = 1'b0;
`endif

   // ---- stage p1: compare observed flags against the shadow ----
   assign mis[1] = run & (full        != exp_comb.full);
   assign mis[2] = run & (empty       != exp_comb.empty);
   assign mis[3] = run & (almostfull  != exp_comb.afull);
   assign mis[4] = run & (almostempty != exp_comb.aempty);
   assign mis[5] = run & reg_vld_p1 & (wr_ack    != exp_wr_ack_p1);
   assign mis[6] = run & reg_vld_p1 & (overflow  != exp_ovf_p1);
   assign mis[7] = run & reg_vld_p1 & (underflow != exp_udf_p1);
   assign mis[8] = run & data_mis;
   assign any_mis = |mis;

   // ---- stage p2: FSM, counters and sticky status ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         err_sticky  <= 1'b0;
         err_count   <= '0;
         chk_count   <= '0;
         first_err_q <= NONE;
      end else begin
         case (state_q)
            IDLE:    if (chk_en) state_q <= RUN;
            RUN: begin
               if (any_mis && halt_on_err) state_q <= HALT;
               else if (!chk_en)           state_q <= IDLE;
            end
            HALT:    if (err_clr) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase

         if (err_clr) begin
            err_sticky  <= 1'b0;
            err_count   <= '0;
            chk_count   <= '0;
            first_err_q <= NONE;
         end else begin
            if (run) chk_count <= sat_add(chk_count, 4'd1);
            if (any_mis) begin
               err_count  <= sat_add(err_count, mis_count(mis));
               err_sticky <= 1'b1;
               if (!err_sticky) first_err_q <= chk_err_e'(lowest_code(mis));
            end
         end
      end
   end

   assign state          = state_q;
   assign first_err_code = first_err_q;

endmodule

// File: tb/tb_fifo_flag_checker.sv
// Randomized bench: a queue-based FIFO model drives the observed signals,
// with occasional corruption, and predicts the checker's verdict.
module tb_fifo_flag_checker;
   localparam int DEPTH = 8;
   localparam int W     = 16;
   localparam int MAXC  = 65535;
   localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          chk_en = 1'b0, halt_on_err = 1'b0, err_clr = 1'b0;
   logic          wr_en = 1'b0, rd_en = 1'b0;
   logic [W-1:0]  data_in = '0, data_out = '0;
   logic          wr_ack = 1'b0, overflow = 1'b0, underflow = 1'b0;
   logic          full = 1'b0, empty = 1'b1, almostfull = 1'b0, almostempty = 1'b0;
   logic          err_sticky;
   logic [15:0]   err_count, chk_count;
   logic [3:0]    first_err_code;
   logic [1:0]    state;

   fifo_flag_checker #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .halt_on_err(halt_on_err),
      .err_clr(err_clr), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
      .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow),
      .underflow(underflow), .full(full), .empty(empty),
      .almostfull(almostfull), .almostempty(almostempty),
      .err_sticky(err_sticky), .err_count(err_count), .chk_count(chk_count),
      .first_err_code(first_err_code), .state(state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference FIFO contents and its registered outputs
   logic [W-1:0] q[$];
   bit           t_wr_ack, t_ovf, t_udf, dchk_pend;
   logic [W-1:0] t_dout;
   // Reference checker verdict
   int m_state, m_err, m_chk, m_first;
   bit m_sticky;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_err_count"}, err_count, m_err);
      check({tag, "_chk_count"}, chk_count, m_chk);
      check({tag, "_sticky"}, err_sticky, m_sticky);
      check({tag, "_first_code"}, first_err_code, m_first);
      check({tag, "_state"}, state, m_state);
   endtask

   task automatic drive_idle();
      wr_en = 0; rd_en = 0; data_in = '0; chk_en = 0; halt_on_err = 0; err_clr = 0;
      wr_ack = 0; overflow = 0; underflow = 0; data_out = '0;
      full = 0; empty = 1; almostfull = 0; almostempty = 0;
   endtask

   task automatic model_reset();
      q.delete();
      t_wr_ack = 0; t_ovf = 0; t_udf = 0; dchk_pend = 0; t_dout = '0;
      m_state = S_IDLE; m_err = 0; m_chk = 0; m_first = 0; m_sticky = 0;
   endtask

   // Assert reset away from the clock edge, confirm it acts at once, then
   // release and let one idle edge pass.
   task automatic async_reset();
      @(negedge clk); #2;
      rst_n = 0;
      drive_idle();
      model_reset();
      #1;
      check_outputs("async_rst");
      @(negedge clk);
      rst_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic cycle(input bit w, input bit r, input logic [W-1:0] din,
                        input bit [6:0] inj, input bit dbad,
                        input bit en, input bit halt, input bit clr);
      int n, nm, code;
      bit tf, te, taf, tae, wacc, racc;
      bit mis[9];
      @(negedge clk);
      n = q.size();
      tf = (n == DEPTH); te = (n == 0); taf = (n == DEPTH - 1); tae = (n == 1);
      wr_en = w; rd_en = r; data_in = din;
      chk_en = en; halt_on_err = halt; err_clr = clr;
      full = tf ^ inj[0]; empty = te ^ inj[1];
      almostfull = taf ^ inj[2]; almostempty = tae ^ inj[3];
      wr_ack = t_wr_ack ^ inj[4]; overflow = t_ovf ^ inj[5]; underflow = t_udf ^ inj[6];
      data_out = t_dout ^ {{(W-1){1'b0}}, dbad};

      for (int i = 0; i < 9; i++) mis[i] = 0;
      if (m_state == S_RUN) begin
         mis[1] = (full != tf);
         mis[2] = (empty != te);
         mis[3] = (almostfull != taf);
         mis[4] = (almostempty != tae);
         mis[5] = (wr_ack != t_wr_ack);
         mis[6] = (overflow != t_ovf);
         mis[7] = (underflow != t_udf);
`ifdef FIFO_CHK_DATA_EN
         mis[8] = dchk_pend && (data_out != t_dout);
`endif
      end
      nm = 0; code = 0;
      for (int i = 1; i <= 8; i++) begin
         if (mis[i]) begin
            nm++;
            if (code == 0) code = i;
         end
      end

      if (clr) begin
         m_err = 0; m_chk = 0; m_sticky = 0; m_first = 0;
      end else begin
         if (m_state == S_RUN) m_chk = (m_chk + 1 > MAXC) ? MAXC : m_chk + 1;
         if (nm > 0) begin
            m_err = (m_err + nm > MAXC) ? MAXC : m_err + nm;
            if (!m_sticky) m_first = code;
            m_sticky = 1;
         end
      end
      case (m_state)
         S_IDLE: if (en) m_state = S_RUN;
         S_RUN: begin
            if (nm > 0 && halt) m_state = S_HALT;
            else if (!en)       m_state = S_IDLE;
         end
         default: if (clr) m_state = S_IDLE;
      endcase

      wacc = w && (n < DEPTH);
      racc = r && (n > 0);
      t_wr_ack = wacc;
      t_ovf = w && (n == DEPTH);
      t_udf = r && (n == 0);
      if (racc) t_dout = q.pop_front();
      if (wacc) q.push_back(din);
      dchk_pend = racc;

      @(posedge clk); #1;
      check_outputs("cyc");
   endtask

   initial begin
      logic [W-1:0] d;
      bit [6:0] inj;
      drive_idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1;
      @(posedge clk); #1;

      // Fill a correct FIFO while checking
      cycle(0, 0, '0, '0, 0, 1, 0, 0);
      for (int i = 0; i < DEPTH; i++) cycle(1, 0, W'($urandom), '0, 0, 1, 0, 0);
      check("fill_chk_count", chk_count, 8);
      check("fill_err_count", err_count, 0);
      check("fill_q_full", q.size(), DEPTH);

      // Write while full, then a missing overflow
      cycle(1, 0, 16'h1111, '0, 0, 1, 0, 0);
      check("ovf_ok_err", err_count, 0);
      cycle(0, 0, '0, 7'b0100000, 0, 1, 0, 0);
      check("ovf_mis_err", err_count, 1);
      check("ovf_mis_code", first_err_code, 6);
      check("ovf_mis_sticky", err_sticky, 1);

      // Drain, then a missing underflow with halt enabled
      cycle(0, 0, '0, '0, 0, 1, 0, 1);
      for (int i = 0; i < DEPTH; i++) cycle(0, 1, '0, '0, 0, 1, 1, 0);
      cycle(0, 1, '0, '0, 0, 1, 1, 0);
      cycle(0, 0, '0, 7'b1000000, 0, 1, 1, 0);
      check("udf_halt_state", state, 2);
      check("udf_err", err_count, 1);
      check("udf_code", first_err_code, 7);
      cycle(0, 0, '0, '0, 0, 1, 1, 0);
      cycle(0, 0, '0, '0, 0, 1, 1, 1);
      check("halt_clr_state", state, 0);
      check("halt_clr_err", err_count, 0);
      check("halt_clr_chk", chk_count, 0);

      // Simultaneous read and write at four entries
      cycle(0, 0, '0, '0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) cycle(1, 0, W'($urandom), '0, 0, 1, 0, 0);
      cycle(1, 1, 16'h2222, '0, 0, 1, 0, 0);
      check("simul_occ", q.size(), 4);
      cycle(0, 0, '0, 7'b0001000, 0, 1, 0, 0);
      check("aempty_code", first_err_code, 4);
      check("aempty_err", err_count, 1);

`ifdef FIFO_CHK_DATA_EN
      cycle(0, 0, '0, '0, 0, 1, 0, 1);
      for (int i = 0; i < 4; i++) cycle(0, 1, '0, '0, 0, 1, 0, 0);
      cycle(1, 0, 16'hA5A5, '0, 0, 1, 0, 0);
      cycle(1, 0, 16'h1234, '0, 0, 1, 0, 0);
      cycle(0, 1, '0, '0, 0, 1, 0, 0);
      cycle(0, 1, '0, '0, 0, 1, 0, 0);
      cycle(0, 0, '0, '0, 1, 1, 0, 0);
      check("data_err", err_count, 1);
      check("data_code", first_err_code, 8);
`endif

      // Accumulate three errors, then reset asynchronously mid-run
      cycle(0, 0, '0, '0, 0, 1, 0, 1);
      for (int i = 0; i < 3; i++) cycle(0, 0, '0, 7'b0000010, 0, 1, 0, 0);
      check("pre_rst_err", err_count, 3);
      async_reset();
      check("post_rst_err", err_count, 0);
      check("post_rst_state", state, 0);
      cycle(0, 0, '0, '0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cycle(1, 0, W'($urandom), '0, 0, 1, 0, 0);
      check("clean_run_state", state, 1);
      check("clean_run_err", err_count, 0);

      // Randomized traffic with sparse corruption
      for (int i = 0; i < 400; i++) begin
         inj = ($urandom % 12 == 0) ? 7'(7'b1 << $urandom_range(0, 6)) : 7'b0;
         d = W'($urandom);
         cycle(bit'($urandom % 3 != 0), bit'($urandom % 2), d, inj,
               bit'($urandom % 16 == 0), bit'($urandom % 20 != 0),
               bit'($urandom % 4 == 0), bit'($urandom % 30 == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
